// File: rtl/seq_counter_param_pkg.sv
// Shared constants and helpers for the programmable sequence counter.
// The default table walks the Johnson-style code 0,1,3,7,F,E,C,8.
package seq_counter_param_pkg;

  localparam int SEQ_WRAP = 0;
  localparam int SEQ_SAT  = 1;

  localparam logic [31:0] SEQ_DEFAULT_TABLE = 32'h8CEF7310;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_LOAD,
    STEP_UP,
    STEP_DOWN
  } step_e;

  // Index register width for a table of `depth` entries, never below 1 bit.
  function automatic int idx_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/seq_counter_param_encoder.sv
// Reverse table lookup: finds the lowest table index whose entry equals data_i.
// hit_o is low when the value does not appear in the table.
module seq_counter_param_encoder
  import seq_counter_param_pkg::*;
#(
  parameter int                     WIDTH     = 4,
  parameter int                     DEPTH     = 8,
  parameter int                     SW        = 3,
  parameter logic [DEPTH*WIDTH-1:0] SEQ_TABLE = '0
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             hit_o,
  output logic [SW-1:0]    index_o
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit_o   = 1'b0;
    index_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (data_i == SEQ_TABLE[i*WIDTH +: WIDTH]) begin
        hit_o   = 1'b1;
        index_o = SW'(i);
      end
    end
  end

endmodule

// File: rtl/seq_counter_param.sv
// Programmable sequence counter: steps an index through a DEPTH-entry code
// table with up/down, wrap/saturate, checked load and terminal-count strobe.
module seq_counter_param
  import seq_counter_param_pkg::*;
#(
  parameter int                     WIDTH     = 4,
  parameter int                     DEPTH     = 8,
  parameter logic [DEPTH*WIDTH-1:0] SEQ_TABLE = SEQ_DEFAULT_TABLE,
  parameter int                     SAT_MODE  = SEQ_WRAP,
  localparam int                    SW        = idx_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data,
  input  logic             Enable,
  input  logic             Up,
  output logic [WIDTH-1:0] Data_out,
  output logic [SW-1:0]    State_out,
  output logic             Terminal,
  output logic             Load_err
);

  localparam logic [SW-1:0] LAST     = SW'(DEPTH - 1);
  localparam bit            SATURATE = (SAT_MODE == SEQ_SAT);

  logic [SW-1:0] idx_q, idx_d;
  logic          term_q, term_d;
  logic          err_q, err_d;
  logic          hit;
  logic [SW-1:0] hit_idx;
  logic          idx_bad;
  step_e         step;

  seq_counter_param_encoder #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .SW       (SW),
    .SEQ_TABLE(SEQ_TABLE)
  ) u_enc (
    .data_i (Data),
    .hit_o  (hit),
    .index_o(hit_idx)
  );

  // Only a non-power-of-2 depth leaves register codes outside the table.
  if (DEPTH < (1 << SW)) begin : g_guard
    assign idx_bad = (idx_q > LAST);
  end else begin : g_noguard
    assign idx_bad = 1'b0;
  end

  always_comb begin
    step = STEP_HOLD;
    if (Load) begin
      step = STEP_LOAD;
    end else if (Enable) begin
      step = Up ? STEP_UP : STEP_DOWN;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    term_d = 1'b0;
    err_d  = 1'b0;
    if (idx_bad) begin
      idx_d = '0;
    end else begin
      unique case (step)
        STEP_LOAD: begin
          if (hit) idx_d = hit_idx;
          else     err_d = 1'b1;
        end
        STEP_UP: begin
          if (idx_q == LAST) begin
            term_d = 1'b1;
            idx_d  = SATURATE ? LAST : '0;
          end else begin
            idx_d = idx_q + SW'(1);
          end
        end
        STEP_DOWN: begin
          if (idx_q == '0) begin
            term_d = 1'b1;
            idx_d  = SATURATE ? '0 : LAST;
          end else begin
            idx_d = idx_q - SW'(1);
          end
        end
        default: idx_d = idx_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      idx_q  <= '0;
      term_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      term_q <= term_d;
      err_q  <= err_d;
    end
  end

  // Table mux straight off the index register; a stray code reads entry 0.
  always_comb begin
    Data_out = SEQ_TABLE[0 +: WIDTH];
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_q == SW'(i)) Data_out = SEQ_TABLE[i*WIDTH +: WIDTH];
    end
  end

  assign State_out = idx_q;
  assign Terminal  = term_q;
  assign Load_err  = err_q;

endmodule

// File: tb/tb_seq_counter_param.sv
// Scoreboard bench for seq_counter_param: default wrap, saturate, and a
// 5-entry 3-bit table instance; expectations are hand-computed per step.
module tb_seq_counter_param;

  logic CLK;
  logic RST_n;

  logic       a_load, a_en, a_up, a_term, a_err;
  logic [3:0] a_data, a_dout;
  logic [2:0] a_st;
  logic       b_load, b_en, b_up, b_term, b_err;
  logic [3:0] b_data, b_dout;
  logic [2:0] b_st;
  logic       c_load, c_en, c_up, c_term, c_err;
  logic [2:0] c_data, c_dout;
  logic [2:0] c_st;

  seq_counter_param u_a (
    .CLK(CLK), .RST_n(RST_n), .Load(a_load), .Data(a_data), .Enable(a_en),
    .Up(a_up), .Data_out(a_dout), .State_out(a_st), .Terminal(a_term),
    .Load_err(a_err)
  );

  seq_counter_param #(.SAT_MODE(1)) u_b (
    .CLK(CLK), .RST_n(RST_n), .Load(b_load), .Data(b_data), .Enable(b_en),
    .Up(b_up), .Data_out(b_dout), .State_out(b_st), .Terminal(b_term),
    .Load_err(b_err)
  );

  // Table 0,1,3,7,6 packed at [i*3 +: 3].
  seq_counter_param #(.WIDTH(3), .DEPTH(5), .SEQ_TABLE(15'h6EC8)) u_c (
    .CLK(CLK), .RST_n(RST_n), .Load(c_load), .Data(c_data), .Enable(c_en),
    .Up(c_up), .Data_out(c_dout), .State_out(c_st), .Terminal(c_term),
    .Load_err(c_err)
  );

  typedef struct {
    int    inst;
    int    idx;
    int    dat;
    bit    term;
    bit    err;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event sample_ev;

  int TA [8] = '{0, 1, 3, 7, 15, 14, 12, 8};
  int TC [5] = '{0, 1, 3, 7, 6};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drv(input int inst, input bit ld, input int d, input bit en, input bit up);
    case (inst)
      0: begin a_load = ld; a_data = 4'(d); a_en = en; a_up = up; end
      1: begin b_load = ld; b_data = 4'(d); b_en = en; b_up = up; end
      default: begin c_load = ld; c_data = 3'(d); c_en = en; c_up = up; end
    endcase
  endtask

  task automatic push(input int inst, input int idx, input bit term, input bit err,
                      input string nm);
    exp_t e;
    e.inst = inst;
    e.idx  = idx;
    e.dat  = (inst == 2) ? TC[idx] : TA[idx];
    e.term = term;
    e.err  = err;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int inst, input bit ld, input int d, input bit en, input bit up,
                      input int idx, input bit term, input bit err, input string nm);
    drv(inst, ld, d, en, up);
    @(posedge CLK);
    push(inst, idx, term, err, nm);
    @(negedge CLK);
    drv(inst, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: drains every pending expectation at each sample point.
  initial begin
    exp_t e;
    int   ai, ad;
    bit   at, ae;
    forever begin
      @(negedge CLK or sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.inst)
          0: begin ai = int'(a_st); ad = int'(a_dout); at = a_term; ae = a_err; end
          1: begin ai = int'(b_st); ad = int'(b_dout); at = b_term; ae = b_err; end
          default: begin ai = int'(c_st); ad = int'(c_dout); at = c_term; ae = c_err; end
        endcase
        n_tests++;
        if (ai != e.idx || ad != e.dat || at != e.term || ae != e.err) begin
          n_fail++;
          $display("FAIL %s: got idx=%0d data=%h term=%0b err=%0b, want idx=%0d data=%h term=%0b err=%0b",
                   e.name, ai, ad, at, ae, e.idx, e.dat, e.term, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_n = 1'b0;
    for (int i = 0; i < 3; i++) drv(i, 1'b0, 0, 1'b0, 1'b0);
    #2;
    push(0, 0, 1'b0, 1'b0, "rst_a");
    push(1, 0, 1'b0, 1'b0, "rst_b");
    push(2, 0, 1'b0, 1'b0, "rst_c");
    -> sample_ev;
    @(negedge CLK);
    RST_n = 1'b1;

    // Count up through a full wrap; Terminal only after 7 -> 0.
    for (int k = 1; k <= 9; k++)
      step(0, 1'b0, 0, 1'b1, 1'b1, k % 8, (k == 8), 1'b0, $sformatf("t1_up%0d", k));

    // Down across index 0 wraps to 7 with a one-cycle strobe.
    step(0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, "t2_dn_to0");
    step(0, 1'b0, 0, 1'b1, 1'b0, 7, 1'b1, 1'b0, "t2_dn_wrap");
    step(0, 1'b0, 0, 1'b0, 1'b0, 7, 1'b0, 1'b0, "t2_hold");

    // Loads: legal, illegal, priority over Enable, no Terminal from Load.
    step(0, 1'b1, 'hE, 1'b0, 1'b0, 5, 1'b0, 1'b0, "t4_load_E");
    step(0, 1'b1, 'h5, 1'b0, 1'b0, 5, 1'b0, 1'b1, "t4_load_bad");
    step(0, 1'b0, 0,   1'b0, 1'b0, 5, 1'b0, 1'b0, "t4_err_clear");
    step(0, 1'b1, 'h3, 1'b1, 1'b1, 2, 1'b0, 1'b0, "t4_load_vs_en");
    step(0, 1'b1, 'h8, 1'b1, 1'b0, 7, 1'b0, 1'b0, "t4_load_8");
    step(0, 1'b1, 'h0, 1'b1, 1'b1, 0, 1'b0, 1'b0, "t4_load_at_end");
    step(0, 1'b1, 'h2, 1'b1, 1'b1, 0, 1'b0, 1'b1, "t4_bad_with_en");
    step(0, 1'b1, 'hF, 1'b0, 1'b0, 4, 1'b0, 1'b0, "t4_load_F");

    // Saturating instance.
    step(1, 1'b1, 'h8, 1'b0, 1'b0, 7, 1'b0, 1'b0, "t3_load_8");
    for (int k = 1; k <= 3; k++)
      step(1, 1'b0, 0, 1'b1, 1'b1, 7, 1'b1, 1'b0, $sformatf("t3_sat_hi%0d", k));
    step(1, 1'b0, 0,   1'b1, 1'b0, 6, 1'b0, 1'b0, "t3_dir_change");
    step(1, 1'b1, 'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "t3_load_0");
    step(1, 1'b0, 0,   1'b1, 1'b0, 0, 1'b1, 1'b0, "t3_sat_lo");
    step(1, 1'b0, 0,   1'b0, 1'b0, 0, 1'b0, 1'b0, "t3_term_clear");
    step(1, 1'b0, 0,   1'b1, 1'b1, 1, 1'b0, 1'b0, "t3_up_from0");

    // Non-power-of-2 depth: indices 5..7 must never appear.
    for (int k = 1; k <= 6; k++)
      step(2, 1'b0, 0, 1'b1, 1'b1, k % 5, (k == 5), 1'b0, $sformatf("t5_up%0d", k));
    step(2, 1'b0, 0,   1'b1, 1'b0, 0, 1'b0, 1'b0, "t5_dn_to0");
    step(2, 1'b0, 0,   1'b1, 1'b0, 4, 1'b1, 1'b0, "t5_dn_wrap");
    step(2, 1'b1, 'h2, 1'b0, 1'b0, 4, 1'b0, 1'b1, "t5_load_bad");
    step(2, 1'b1, 'h7, 1'b0, 1'b0, 3, 1'b0, 1'b0, "t5_load_7");
    step(2, 1'b1, 'h0, 1'b1, 1'b1, 0, 1'b0, 1'b0, "t5_load_0");

    // Arrange both strobes high and a nonzero index, then reset between edges.
    step(0, 1'b1, 'h8, 1'b0, 1'b0, 7, 1'b0, 1'b0, "t6_load_8");
    drv(0, 1'b0, 0, 1'b1, 1'b1);
    drv(1, 1'b0, 0, 1'b1, 1'b1);
    drv(2, 1'b1, 'h5, 1'b0, 1'b0);
    @(posedge CLK);
    push(0, 0, 1'b1, 1'b0, "t6_pre_a");
    push(1, 2, 1'b0, 1'b0, "t6_pre_b");
    push(2, 0, 1'b0, 1'b1, "t6_pre_c");
    @(negedge CLK);
    for (int i = 0; i < 3; i++) drv(i, 1'b0, 0, 1'b0, 1'b0);
    #1;
    RST_n = 1'b0;
    #1;
    push(0, 0, 1'b0, 1'b0, "t6_async_a");
    push(1, 0, 1'b0, 1'b0, "t6_async_b");
    push(2, 0, 1'b0, 1'b0, "t6_async_c");
    -> sample_ev;
    drv(0, 1'b0, 0, 1'b1, 1'b1);
    @(negedge CLK);
    RST_n = 1'b1;
    step(0, 1'b0, 0, 1'b1, 1'b1, 1, 1'b0, 1'b0, "t6_resume1");
    step(0, 1'b0, 0, 1'b1, 1'b1, 2, 1'b0, 1'b0, "t6_resume2");

    @(negedge CLK);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
